xor_stream_descrambler: RTL and testbench

//  Receive end of the XOR scrambled word link: recovers plaintext 32-bit words that the transmit side

---
 rtl/xds_pkg.sv | 21 ++
 rtl/xor_stream_descrambler_if.sv | 39 +++
 rtl/xor_lfsr_adv32.sv | 18 +
 rtl/xorgate32bit.sv | 10 +
 rtl/xor_stream_descrambler.sv | 112 +++++++++++
 tb/tb_xor_stream_descrambler.sv | 238 +++++++++++++++++++++++
 6 files changed

// File: rtl/xds_pkg.sv
// Shared constants, buffer state type and single LFSR step for the XOR stream descrambler.
package xds_pkg;

  localparam int unsigned XDS_WIDTH         = 32;
  localparam logic [31:0] XDS_POLY          = 32'hEDB88320;
  localparam logic [31:0] XDS_SEED_FALLBACK = 32'h0000_0001;
  localparam int unsigned XDS_CNT_W         = 16;

  typedef enum logic [1:0] {
    XDS_EMPTY,
    XDS_ONE,
    XDS_TWO
  } xds_buf_state_e;

  // One Galois right-shift step of the keystream generator.
  function automatic logic [31:0] xds_step(input logic [31:0] s,
                                           input logic [31:0] poly = XDS_POLY);
    return {1'b0, s[31:1]} ^ (s[0] ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/xor_stream_descrambler_if.sv
// Valid/ready stream, seed control and counter bundle for the descrambler.
// XOR_DESCRAMBLER_BYPASS_EN adds the per-word bypass input.
interface xor_stream_descrambler_if
  import xds_pkg::*;
#(
  parameter int unsigned CNT_W = XDS_CNT_W
);
  logic                 seed_load;
  logic [XDS_WIDTH-1:0] seed;
  logic                 in_valid;
  logic                 in_ready;
  logic [XDS_WIDTH-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [XDS_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]     word_cnt;
`ifdef XOR_DESCRAMBLER_BYPASS_EN
  logic                 bypass;
`endif

  // Link/processor side driving the descrambler.
  modport master (
    output seed_load, seed, in_valid, in_data, out_ready,
`ifdef XOR_DESCRAMBLER_BYPASS_EN
    output bypass,
`endif
    input  in_ready, out_valid, out_data, word_cnt
  );

  // The descrambler itself.
  modport slave (
    input  seed_load, seed, in_valid, in_data, out_ready,
`ifdef XOR_DESCRAMBLER_BYPASS_EN
    input  bypass,
`endif
    output in_ready, out_valid, out_data, word_cnt
  );

endinterface

// File: rtl/xor_lfsr_adv32.sv
// Combinational advance of the keystream LFSR by one full word (32 unrolled steps).
module xor_lfsr_adv32
  import xds_pkg::*;
#(
  parameter logic [31:0] POLY = XDS_POLY
) (
  input  logic [31:0] state_i,
  output logic [31:0] next_o
);

  always_comb begin
    next_o = state_i;
    for (int i = 0; i < 32; i++) begin
      next_o = xds_step(next_o, POLY);
    end
  end

endmodule

// File: rtl/xorgate32bit.sv
// 32-bit bitwise XOR used to strip the keystream from a received word.
module xorgate32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_stream_descrambler.sv
// Receive-side XOR descrambler: keystream LFSR, accepted-word counter and 2-entry output buffer.
// XOR_DESCRAMBLER_BYPASS_EN enables the per-word bypass input.
module xor_stream_descrambler
  import xds_pkg::*;
#(
  parameter int unsigned WIDTH = XDS_WIDTH,
  parameter logic [31:0] POLY  = XDS_POLY,
  parameter int unsigned CNT_W = XDS_CNT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  xor_stream_descrambler_if.slave     bus
);

  localparam logic [WIDTH-1:0] SEED_FB = WIDTH'(XDS_SEED_FALLBACK);

  xds_buf_state_e   state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             head_q, head_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] lfsr_adv;
  logic [WIDTH-1:0] xor_word;
  logic [WIDTH-1:0] word_c;
  logic             use_bypass;
  logic             accept;
  logic             pop;
  logic             wr_ptr;

  xor_lfsr_adv32 #(.POLY(POLY)) u_adv (
    .state_i (lfsr_q),
    .next_o  (lfsr_adv)
  );

  xorgate32bit u_xor (
    .a (bus.in_data),
    .b (lfsr_q),
    .y (xor_word)
  );

`ifdef XOR_DESCRAMBLER_BYPASS_EN
  assign use_bypass = bus.bypass;
`else
  assign use_bypass = 1'b0;
`endif

  assign word_c        = use_bypass ? bus.in_data : xor_word;
  assign bus.in_ready  = (state_q != XDS_TWO) && !bus.seed_load && !reset;
  assign bus.out_valid = (state_q != XDS_EMPTY);
  assign bus.out_data  = mem_q[head_q];
  assign bus.word_cnt  = cnt_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= XDS_EMPTY;
      lfsr_q   <= SEED_FB;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      head_q   <= head_d;
      cnt_q    <= cnt_d;
    end
  end

  // Buffer occupancy, keystream and counter next-state.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    head_d   = head_q;
    cnt_d    = cnt_q;
    // New word goes behind the head when one entry is already held.
    wr_ptr   = head_q ^ (state_q == XDS_ONE);

    case (state_q)
      XDS_EMPTY: if (accept) state_d = XDS_ONE;
      XDS_ONE: begin
        if (accept && !pop)      state_d = XDS_TWO;
        else if (pop && !accept) state_d = XDS_EMPTY;
      end
      XDS_TWO:   if (pop) state_d = XDS_ONE;
      default:   state_d = XDS_EMPTY;
    endcase

    if (pop) head_d = ~head_q;

    if (accept) begin
      mem_d[wr_ptr] = word_c;
      cnt_d         = cnt_q + CNT_W'(1);
      if (!use_bypass) lfsr_d = lfsr_adv;
    end

    // Zero seed would lock the LFSR, so it falls back to the reset state.
    if (bus.seed_load) begin
      lfsr_d = (bus.seed == '0) ? SEED_FB : bus.seed;
      cnt_d  = '0;
    end
  end

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_xor_stream_descrambler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  xor_stream_descrambler_if #(.CNT_W(16)) bus ();

  xor_stream_descrambler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Keystream advance by one word, straight from the step rule.
  function automatic logic [31:0] ks_next(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    repeat (32) r = (r >> 1) ^ (r[0] ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: FIFO of plaintext words, keystream state and counter.
  logic [31:0] m_q[$];
  logic [31:0] m_ks = 32'h1;
  int unsigned m_cnt = 0;

  always @(negedge clk) begin
    logic exp_ready;
    logic do_pop;
    logic do_acc;
    logic byp;
    if (reset) begin
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
      m_q.delete();
      m_ks  = 32'h1;
      m_cnt = 0;
    end else begin
      exp_ready = (m_q.size() < 2) && !bus.seed_load;
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("out_data", bus.out_data, m_q[0]);
      chk("word_cnt", 32'(bus.word_cnt), m_cnt % 65536);
      do_pop = (m_q.size() != 0) && bus.out_ready;
      do_acc = bus.in_valid && exp_ready;
`ifdef XOR_DESCRAMBLER_BYPASS_EN
      byp = bus.bypass;
`else
      byp = 1'b0;
`endif
      if (do_pop) void'(m_q.pop_front());
      if (do_acc) begin
        m_q.push_back(byp ? bus.in_data : (bus.in_data ^ m_ks));
        if (!byp) m_ks = ks_next(m_ks);
        m_cnt++;
      end
      if (bus.seed_load) begin
        m_ks  = (bus.seed == 32'h0) ? 32'h1 : bus.seed;
        m_cnt = 0;
      end
    end
  end

  task automatic load_seed(input logic [31:0] s);
    bus.seed_load = 1'b1;
    bus.seed      = s;
    step();
    bus.seed_load = 1'b0;
  endtask

  initial begin
    logic [31:0] tx_ks;
    logic [31:0] p;
    bus.seed_load = 1'b0;
    bus.seed      = 32'h0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b0;
`ifdef XOR_DESCRAMBLER_BYPASS_EN
    bus.bypass    = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;

    // 1: zero seed falls back to 1
    load_seed(32'h0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_out_data", bus.out_data, 32'hDEADBEEE);
    chk("t1_word_cnt", 32'(bus.word_cnt), 32'd1);
    step();

    // 2: round trip with transmit-side scrambling
    load_seed(32'h12345678);
    tx_ks = 32'h12345678;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      p = $urandom;
      bus.in_data = p ^ tx_ks;
      tx_ks = ks_next(tx_ks);
      step();
      chk("t2_plain", bus.out_data, p);
    end
    bus.in_valid = 1'b0;
    chk("t2_word_cnt", 32'(bus.word_cnt), 32'd1000);
    step();

    // 3: backpressure fills two entries and holds the head
    load_seed(32'hA5A5A5A5);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0F0F0F0F;
    step();
    bus.in_data = $urandom;
    step();
    bus.in_data = $urandom;
    chk("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
    chk("t3_head", bus.out_data, 32'hAAAAAAAA);
    step();
    chk("t3_head_hold", bus.out_data, 32'hAAAAAAAA);
    bus.out_ready = 1'b1;
    step();
    chk("t3_in_ready_one", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("t3_word_cnt", 32'(bus.word_cnt), 32'd3);
    step();

    // 4: seed_load while one word is buffered
    load_seed(32'h0000FFFF);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h0;
    step();
    chk("t4_buffered", bus.out_data, 32'h0000FFFF);
    bus.seed_load = 1'b1;
    bus.seed      = 32'hF0F0F0F0;
    bus.in_data   = 32'h11111111;
    bus.out_ready = 1'b1;
    #1;
    chk("t4_no_accept", 32'(bus.in_ready), 32'd0);
    step();
    bus.seed_load = 1'b0;
    chk("t4_drained", 32'(bus.out_valid), 32'd0);
    chk("t4_cnt_clear", 32'(bus.word_cnt), 32'd0);
    step();
    chk("t4_new_seed", bus.out_data, 32'hE1E1E1E1);
    chk("t4_cnt_one", 32'(bus.word_cnt), 32'd1);
    bus.in_valid = 1'b0;
    step();

    // 5: reset with buffer full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = $urandom;
    step();
    step();
    chk("t5_full", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_word_cnt", 32'(bus.word_cnt), 32'd0);
    chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    reset = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b1;
    step();
    chk("t5_restart_ks", bus.out_data, 32'h00000001);
    bus.in_valid = 1'b0;
    step();

`ifdef XOR_DESCRAMBLER_BYPASS_EN
    // 6: bypass leaves the keystream untouched
    load_seed(32'hC3C3C3C3);
    bus.in_valid = 1'b1;
    bus.bypass   = 1'b1;
    bus.in_data  = 32'h13572468;
    step();
    chk("t6_bypass", bus.out_data, 32'h13572468);
    bus.bypass  = 1'b0;
    bus.in_data = 32'h0;
    step();
    chk("t6_first_ks", bus.out_data, 32'hC3C3C3C3);
    chk("t6_word_cnt", 32'(bus.word_cnt), 32'd2);
    bus.in_valid = 1'b0;
    step();
`endif

    // Randomized traffic with occasional seed loads and resets
    for (int i = 0; i < 4000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.seed_load = ($urandom_range(0, 40) == 0);
      bus.seed      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
`ifdef XOR_DESCRAMBLER_BYPASS_EN
      bus.bypass    = ($urandom_range(0, 4) == 0);
`endif
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.seed_load = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
